// File: rtl/prewrapper_pkg.sv
// prewrapper_pkg: response codes, FSM state encodings and register-map constants
// shared by the AXI4-Lite front end and its address checker.
package prewrapper_pkg;
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [31:0] DUT_IN_BASE = 32'h0000_0000;
    localparam logic [31:0] DUT_OUT_BASE = 32'h0000_0200;
    localparam logic [31:0] DFT_OUT_BASE = 32'h0000_0400;
    localparam logic [31:0] DFT_OUT_WORDS = 32'h0000_0020;
    localparam logic [31:0] MAP_LIMIT = DFT_OUT_BASE + DFT_OUT_WORDS;
    localparam logic [31:0] TEST_BASE = 32'hFF00_0000;
    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_COMMIT, R_WAIT, R_RESP} rd_state_t;
endpackage

// File: rtl/prewrapper_addr_check.sv
// prewrapper_addr_check: flags a word address as mapped (below LIMIT or one of the two test words).
module prewrapper_addr_check import prewrapper_pkg::*; #(
    parameter logic [31:0] LIMIT = MAP_LIMIT,
    parameter logic [31:0] TBASE = TEST_BASE
) (
    input  logic [31:0] word,
    output logic        mapped
);
    assign mapped = word < LIMIT || word == TBASE || word == TBASE + 32'd1;
endmodule

// File: rtl/axi_prewrapper_lite_slave.sv
// axi_prewrapper_lite_slave: AXI4-Lite slave turning bus accesses into one-cycle register-file strobes.
// Optional SLVERR counter enabled by defining PREWRAPPER_LITE_ERRCNT_EN.
module axi_prewrapper_lite_slave #(
    parameter int          RD_LAT     = 1,
    parameter logic [31:0] ADDR_LIMIT = prewrapper_pkg::MAP_LIMIT,
    parameter logic [31:0] TEST_BASE  = prewrapper_pkg::TEST_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] s_awaddr,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,
    input  logic [31:0] s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [31:0] rf_wr_addr,
    output logic [31:0] rf_wr_msg,
    output logic        rf_wr_en,
    output logic [31:0] rf_rd_addr,
    output logic        rf_rd_en,
    input  logic [31:0] rf_rd_msg,
    output logic [15:0] err_count
);
    import prewrapper_pkg::*;

    wr_state_t ws, ws_nx;
    rd_state_t rs, rs_nx;
    logic rdy_en, aw_got, w_got, w_map, r_map, wr_ok, stall, last_wait, sample;
    logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic [3:0] wstrb_q;
    logic [1:0] rcnt;

    prewrapper_addr_check #(.LIMIT(ADDR_LIMIT), .TBASE(TEST_BASE)) u_wr_check (
        .word(rf_wr_addr), .mapped(w_map)
    );
    prewrapper_addr_check #(.LIMIT(ADDR_LIMIT), .TBASE(TEST_BASE)) u_rd_check (
        .word(rf_rd_addr), .mapped(r_map)
    );

    // rdy_en keeps the readies low during reset and for the edge that releases it
    assign s_awready = rdy_en && ws == W_IDLE && !aw_got;
    assign s_wready = rdy_en && ws == W_IDLE && !w_got;
    assign s_arready = rdy_en && rs == R_IDLE;
    assign s_bvalid = ws == W_RESP;
    assign s_rvalid = rs == R_RESP;
    assign aw_hs = s_awvalid && s_awready;
    assign w_hs = s_wvalid && s_wready;
    assign ar_hs = s_arvalid && s_arready;
    assign b_hs = s_bvalid && s_bready;
    assign r_hs = s_rvalid && s_rready;
    assign wr_ok = w_map && wstrb_q == 4'hF;
    // a read commit on the word being written waits so it observes the new data
    assign stall = rs == R_COMMIT && ws == W_COMMIT && rf_rd_addr == rf_wr_addr;
    assign last_wait = rs == R_WAIT && {1'b0, rcnt} + 3'd1 == 3'(RD_LAT);
    assign sample = (rs == R_COMMIT && !stall && RD_LAT == 0) || last_wait;

    always_comb begin
        ws_nx = ws;
        rs_nx = rs;
        ws_nx = (ws == W_IDLE && (aw_got || aw_hs) && (w_got || w_hs)) ? W_COMMIT :
                ws == W_COMMIT ? W_RESP :
                (ws == W_RESP && s_bready) ? W_IDLE : ws;
        rs_nx = (rs == R_IDLE && ar_hs) ? R_COMMIT :
                (rs == R_COMMIT && !stall) ? (RD_LAT == 0 ? R_RESP : R_WAIT) :
                last_wait ? R_RESP :
                (rs == R_RESP && s_rready) ? R_IDLE : rs;
        rf_wr_en = ws == W_COMMIT && wr_ok;
        rf_rd_en = rs == R_COMMIT && !stall && r_map;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ws <= W_IDLE;
            rs <= R_IDLE;
            rdy_en <= 1'b0;
        end else begin
            ws <= ws_nx;
            rs <= rs_nx;
            rdy_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aw_got <= 1'b0;
            w_got <= 1'b0;
            wstrb_q <= '0;
            rf_wr_addr <= '0;
            rf_wr_msg <= '0;
            rf_rd_addr <= '0;
            s_bresp <= OKAY;
            s_rresp <= OKAY;
            s_rdata <= '0;
            rcnt <= '0;
        end else begin
            if (aw_hs) begin
                rf_wr_addr <= s_awaddr >> 2;
                aw_got <= 1'b1;
            end
            if (w_hs) begin
                rf_wr_msg <= s_wdata;
                wstrb_q <= s_wstrb;
                w_got <= 1'b1;
            end
            if (ws == W_COMMIT) begin
                aw_got <= 1'b0;
                w_got <= 1'b0;
                s_bresp <= wr_ok ? OKAY : SLVERR;
            end
            if (ar_hs)
                rf_rd_addr <= s_araddr >> 2;
            rcnt <= rs == R_WAIT ? rcnt + 2'd1 : 2'd0;
            if (sample) begin
                s_rdata <= r_map ? rf_rd_msg : 32'd0;
                s_rresp <= r_map ? OKAY : SLVERR;
            end
        end
    end

`ifdef PREWRAPPER_LITE_ERRCNT_EN
    logic [16:0] err_sum;
    assign err_sum = {1'b0, err_count} + 17'(b_hs && s_bresp == SLVERR) + 17'(r_hs && s_rresp == SLVERR);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err_count <= '0;
        else
            err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
`else
    assign err_count = '0;
`endif
endmodule
